rf_wb_sched: RTL and testbench

- Write-back scheduler and scoreboard for the single-write-port 32x32 integer register file.
- Arbitrates NREQ write-back sources (ALU, load unit, CSR/mul) onto the one RF write port through a registered output stage.
- Tracks pending destination registers in a busy scoreboard and stalls issue on RAW/WAW hazards.
- Sits between the issue stage, the execution units and the register file.

---
 rtl/rf_wb_sched.sv | 175 +++++++++++++++++
 tb/tb_rf_wb_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rf_wb_sched                                                     |
// | Purpose  : Write-back arbiter plus busy scoreboard for the single-write-   |
// |            port 32x32 register file. It selects one of NREQ write-back     |
// |            sources, registers it onto the RF write port, and stalls issue  |
// |            on RAW/WAW hazards against pending destination registers.       |
// | Options  : RF_WB_RR_EN - defined: round-robin arbitration;                 |
// |                          undefined: fixed priority (index 0 highest).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rf_wb_sched #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_wen,
  output logic                 issue_stall,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*5-1:0]    wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 rf_wr,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_wrdata,
  output logic [31:0]          busy
);

  logic [NREQ-1:0] w_grant;
  logic            w_found;
  logic            w_xfer;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic            w_set;
  logic            w_stall;
  logic [31:0]     w_busy_nxt;

  logic            r_rf_wr;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wrdata;
  logic [31:0]     r_busy;

`ifdef RF_WB_RR_EN
  localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [c_ptr_w-1:0] r_rr_ptr;
  logic [c_ptr_w-1:0] w_sel_idx;

  // Round-robin grant: first scan indices above the last winner, then wrap.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && wb_valid[i] && (i > int'(r_rr_ptr))) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && wb_valid[i] && (i <= int'(r_rr_ptr))) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Encode the one-hot grant so the pointer can remember the winner.
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = c_ptr_w'(i);
      end
    end
  end

  // Pointer moves only on an actual transfer; reset makes requester 0 next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= c_ptr_w'(NREQ - 1);
    end else if (w_xfer) begin
      r_rr_ptr <= w_sel_idx;
    end
  end
`else
  // Fixed priority grant: the lowest valid index wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && wb_valid[i]) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

  // Grant only ever lands on a valid requester, so any grant is a transfer.
  assign w_xfer   = |w_grant;
  assign wb_ready = w_grant;

  // Steer the granted requester's destination and data to the output stage.
  always_comb begin
    w_sel_rd   = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_rd   = wb_rd[5*i +: 5];
        w_sel_data = wb_data[XLEN*i +: XLEN];
      end
    end
  end

  // RF write port register; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wr     <= 1'b0;
      r_rf_rd     <= '0;
      r_rf_wrdata <= '0;
    end else begin
      r_rf_wr <= w_xfer;
      if (w_xfer) begin
        r_rf_rd     <= w_sel_rd;
        r_rf_wrdata <= w_sel_data;
      end
    end
  end

  // Hazard check against pending writes; no forwarding path exists.
  always_comb begin
    w_stall = 1'b0;
    if (issue_valid) begin
      w_stall = ((issue_rs1 != 5'd0) && r_busy[issue_rs1]) ||
                ((issue_rs2 != 5'd0) && r_busy[issue_rs2]) ||
                (issue_wen && (issue_rd != 5'd0) && r_busy[issue_rd]);
    end
  end

  assign w_set = issue_valid && !w_stall && issue_wen && (issue_rd != 5'd0);

  // Clear on RF commit first, then set, so a same-edge set wins; x0 never busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_wr) begin
      w_busy_nxt[r_rf_rd] = 1'b0;
    end
    if (w_set) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign issue_stall = w_stall;
  assign rf_wr       = r_rf_wr;
  assign rf_rd       = r_rf_rd;
  assign rf_wrdata   = r_rf_wrdata;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rf_wb_sched                                                  |
// | Purpose  : Directed, table-driven self-checking bench for rf_wb_sched.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rf_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 issue_valid;
  logic [4:0]           issue_rs1;
  logic [4:0]           issue_rs2;
  logic [4:0]           issue_rd;
  logic                 issue_wen;
  logic                 issue_stall;
  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*5-1:0]    wb_rd;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_ready;
  logic                 rf_wr;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_wrdata;
  logic [31:0]          busy;

  int errors = 0;
  int checks = 0;

  rf_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_wen   (issue_wen),
    .issue_stall (issue_stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .rf_wr       (rf_wr),
    .rf_rd       (rf_rd),
    .rf_wrdata   (rf_wrdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [2:0]  wbv;
    logic [4:0]  wrd;
    logic        ex_stall;
    logic [2:0]  ex_ready;
    logic        ex_wr;
    logic [4:0]  ex_rd;
    logic [31:0] ex_busy;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] wb_val(input int idx, input logic [4:0] rd);
    return 32'hD000_0000 | (32'(idx) << 8) | 32'(rd);
  endfunction

  function automatic int onehot_idx(input logic [2:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [2:0] wbv,
                       input logic [4:0] wrd);
    issue_valid = iv;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
    issue_wen   = wen;
    wb_valid    = wbv;
    wb_rd       = {wrd, wrd, wrd};
    wb_data     = {wb_val(2, wrd), wb_val(1, wrd), wb_val(0, wrd)};
  endtask

  logic [2:0] arb_exp [4];

  initial begin
    // iv rs1 rs2 rd wen wbv wrd | stall ready wr rd busy
    vecs[0]  = '{1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0000_0020};
    vecs[1]  = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 3'b000, 5'd0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0000_0020};
    vecs[2]  = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 3'b001, 5'd5, 1'b1, 3'b001, 1'b1, 5'd5, 32'h0000_0020};
    vecs[3]  = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 3'b000, 5'd0, 1'b1, 3'b000, 1'b0, 5'd5, 32'h0000_0000};
    vecs[4]  = '{1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd5, 32'h0000_0040};
    vecs[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b010, 5'd7, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0000_0040};
    vecs[6]  = '{1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd7, 32'h0000_00C0};
    vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b100, 5'd6, 1'b0, 3'b100, 1'b1, 5'd6, 32'h0000_00C0};
    vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd6, 32'h0000_0080};
    vecs[9]  = '{1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 3'b000, 5'd0, 1'b1, 3'b000, 1'b0, 5'd6, 32'h0000_0080};
    vecs[10] = '{1'b1, 5'd1, 5'd1, 5'd7, 1'b0, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd6, 32'h0000_0080};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 5'd0, 1'b0, 3'b001, 1'b1, 5'd0, 32'h0000_0080};
    vecs[12] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0000_0080};
    vecs[13] = '{1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0000_0080};
    vecs[14] = '{1'b1, 5'd0, 5'd7, 5'd9, 1'b1, 3'b000, 5'd0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0000_0080};

`ifdef RF_WB_RR_EN
    arb_exp[0] = 3'b001; arb_exp[1] = 3'b010; arb_exp[2] = 3'b100; arb_exp[3] = 3'b001;
`else
    arb_exp[0] = 3'b001; arb_exp[1] = 3'b001; arb_exp[2] = 3'b001; arb_exp[3] = 3'b001;
`endif

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0);
    #1;
    chk("reset_rf_wr", 32'(rf_wr), 32'd0);
    chk("reset_rf_rd", 32'(rf_rd), 32'd0);
    chk("reset_rf_wrdata", rf_wrdata, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_ready", 32'(wb_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      drive(vecs[v].iv, vecs[v].rs1, vecs[v].rs2, vecs[v].rd, vecs[v].wen,
            vecs[v].wbv, vecs[v].wrd);
      #1;
      chk($sformatf("v%0d_stall", v), 32'(issue_stall), 32'(vecs[v].ex_stall));
      chk($sformatf("v%0d_ready", v), 32'(wb_ready), 32'(vecs[v].ex_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rf_wr", v), 32'(rf_wr), 32'(vecs[v].ex_wr));
      chk($sformatf("v%0d_rf_rd", v), 32'(rf_rd), 32'(vecs[v].ex_rd));
      chk($sformatf("v%0d_busy", v), busy, vecs[v].ex_busy);
      if (vecs[v].ex_wr)
        chk($sformatf("v%0d_rf_wrdata", v), rf_wrdata,
            wb_val(onehot_idx(vecs[v].ex_ready), vecs[v].ex_rd));
    end

    // Fill the scoreboard: every register except x0 (x7 already pending)
    for (int k = 1; k < 32; k++) begin
      if (k != 7) begin
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 5'(k), 1'b1, 3'b000, 5'd0);
        #1;
        chk($sformatf("fill%0d_stall", k), 32'(issue_stall), 32'd0);
        @(posedge clk);
      end
    end
    #1;
    chk("fill_busy", busy, 32'hFFFF_FFFE);

    // Writing x0 never stalls and never marks x0 busy
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'b000, 5'd0);
    #1;
    chk("x0_issue_stall", 32'(issue_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("x0_issue_busy", busy, 32'hFFFF_FFFE);

    // Write-back to x0 is still granted and written
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 5'd0);
    @(posedge clk);
    #1;
    chk("x0_wb_rf_wr", 32'(rf_wr), 32'd1);
    chk("x0_wb_rf_rd", 32'(rf_rd), 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0);
    @(posedge clk);
    #1;
    chk("x0_wb_busy", busy, 32'hFFFF_FFFE);
    chk("x0_wb_idle", 32'(rf_wr), 32'd0);

    // Asynchronous reset while a write is in flight
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b001, 5'd3);
    @(posedge clk);
    #1;
    chk("pre_rst_rf_wr", 32'(rf_wr), 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rf_wr", 32'(rf_wr), 32'd0);
    chk("async_rst_busy", busy, 32'd0);
    chk("async_rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("async_rst_rf_wrdata", rf_wrdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters held valid: arbitration sequence from reset
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b111, 5'd0);
      #1;
      chk($sformatf("arb%0d_ready", c), 32'(wb_ready), 32'(arb_exp[c]));
      @(posedge clk);
      #1;
      chk($sformatf("arb%0d_rf_wr", c), 32'(rf_wr), 32'd1);
      chk($sformatf("arb%0d_rf_wrdata", c), rf_wrdata, wb_val(onehot_idx(arb_exp[c]), 5'd0));
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 5'd0);
    @(posedge clk);
    #1;
    chk("final_idle", 32'(rf_wr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
